div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the EX stage of the pipelined CPU (DIV/DIVU).
- Consumes operands from the ID/EX pipeline register.
- Asserts a stall to freeze the upstream pipeline registers while it runs.
- Delivers quotient (LO) and remainder (HI) to the HI/LO write path.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
start  input  1  request a divide this cycle; only accepted in IDLE.
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
annul  input  1  pipeline flush; aborts the operation in progress.
a  input  WIDTH  dividend; sampled with start.
b  input  WIDTH  divisor; sampled with start.
stall  output  1  freeze request to upstream pipeline registers.
done  output  1  one-cycle pulse; quo/rem valid.
quo  output  WIDTH  quotient (to LO).
rem  output  WIDTH  remainder (to HI).

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State goes to IDLE.
  - done=0; quo=0; rem=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation; no done pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 and annul=0, latch a, b and signed_div.
  - Compute magnitudes |a| and |b| (unsigned for DIVU).
  - Record sign_q = sign(a) XOR sign(b) and sign_r = sign(a) (signed only).
  - Zero the partial remainder, clear the iteration counter, go to CALC.
- CALC (exactly WIDTH cycles):
  - Each cycle: shift {partial_rem, dividend} left by 1.
  - Trial subtract |b| from the (WIDTH+1)-bit partial remainder.
  - If non-negative: keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - After iteration WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Negate the quotient if sign_q=1; negate the remainder if sign_r=1 (DIV only).
  - Load results into quo/rem; go to DONE.
- DONE (1 cycle):
  - done=1; go to IDLE.
  - quo/rem hold their values until the next FIX load (they remain stable after done falls).
- Latency: start sampled at edge E0.
  - CALC occupies cycles E0+1..E0+WIDTH; FIX occupies cycle E0+WIDTH+1.
  - done=1 during cycle E0+WIDTH+2 (cycle 34 for WIDTH=32).
- stall (combinational):
  - Asserted when (state==IDLE and start=1 and annul=0), or state is CALC or FIX.
  - Deasserted in DONE so the pipeline advances in the same cycle done=1.
- start:
  - Ignored in CALC, FIX and DONE. There is no queueing.
  - start in the cycle after DONE (IDLE) is accepted normally.
- annul:
  - annul=1 in CALC or FIX returns to IDLE at the next edge, with no done pulse; quo/rem keep their previous values.
  - annul=1 in IDLE blocks acceptance of start.
  - annul=1 in DONE has no effect; done still pulses.
- Divide by zero (b=0): same latency, with the sign fix bypassed.
  - quo = all ones (0xFFFFFFFF).
  - rem = original a.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (−1) gives quo=0x80000000, rem=0. No exception is raised.
- Sign convention: remainder takes the sign of the dividend; the quotient is truncated toward zero.
- Arithmetic width:
  - Magnitudes are WIDTH-bit unsigned; |0x80000000| = 0x80000000 unsigned.
  - The partial remainder is WIDTH+1 bits, so the trial subtraction never overflows.

Test Plan:
- DIVU a=100, b=7, start at E0 -> stall=1 for cycles E0..E0+33; done=1 at cycle E0+34 only; quo=14, rem=2; stall=0 in the done cycle.
- DIV a=−7 (0xFFFFFFF9), b=2 -> quo=0xFFFFFFFD (−3), rem=0xFFFFFFFF (−1). Then DIV a=7, b=−2 -> quo=−3, rem=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> quo=0x80000000, rem=0. DIVU a=0xFFFFFFFF, b=1 -> quo=0xFFFFFFFF, rem=0.
- b=0 with a=0x12345678, both DIV and DIVU -> done after 34 cycles; quo=0xFFFFFFFF, rem=0x12345678.
- Abort cases:
  - annul=1 at CALC iteration 10 -> IDLE next edge; no done; quo/rem keep the prior result; stall=0.
  - A second start during CALC -> ignored; the first result is unchanged.
  - Back-to-back start in the cycle after done -> accepted.
- rst driven low at CALC iteration 20 -> outputs 0 immediately (asynchronous); after rst=1, no done until a new start; a subsequent 50/5 -> quo=10, rem=0.

Source files
------------

// File: rtl/div_unit_if.sv
// Operand/result bundle between the ID/EX stage and the iterative divider.
// Handshake: the pipeline raises start with operands valid; the divider takes them
// only while idle and annul=0 and asserts stall until the result is ready. done pulses
// for one cycle with quo/rem valid, and quo/rem then hold until the next result.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, signed_div, annul, a, b,
        input  stall, done, quo, rem
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output stall, done, quo, rem
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: magnitudes are divided over WIDTH cycles,
// then the signs are applied in a single fix-up cycle before the done pulse.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
    logic             div0;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic             accept;
    logic             last;
    logic             stall_c;
    logic             done_c;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign accept    = bus.start && !bus.annul;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign a_mag     = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // The stored remainder is always below the divisor, so WIDTH bits suffice;
    // the trial subtraction itself is carried out at WIDTH+1 bits.
    assign shifted   = {prem, dvd[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs};

    assign bus.stall = stall_c;
    assign bus.done  = done_c;
    assign bus.quo   = quo_r;
    assign bus.rem   = rem_r;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_c  = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                stall_c = 1'b1;
                if (bus.annul)  state_nx = IDLE;
                else if (last)  state_nx = FIX;
            end
            FIX: begin
                stall_c  = 1'b1;
                state_nx = bus.annul ? IDLE : DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            prem   <= '0;
            dvd    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        prem   <= '0;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        sign_q <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        sign_r <= bus.signed_div & bus.a[WIDTH-1];
                        div0   <= (bus.b == '0);
                    end
                end
                CALC: begin
                    if (!bus.annul) begin
                        cnt <= cnt + 1'b1;
                        if (!diff[WIDTH]) begin
                            prem <= diff[WIDTH-1:0];
                            dvd  <= {dvd[WIDTH-2:0], 1'b1};
                        end else begin
                            prem <= shifted[WIDTH-1:0];
                            dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                FIX: begin
                    // With b=0 the quotient is all ones and the remainder is |a|;
                    // re-applying the dividend sign restores the original a.
                    if (!bus.annul) begin
                        quo_r <= (sign_q && !div0) ? -dvd : dvd;
                        rem_r <= sign_r ? -prem : prem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
